// File: rtl/regseq_pkg.sv
// regseq_pkg: FSM state encoding and command record shared by the register-file sequencer.
// Command fields are sized for the widest supported configuration; users slice what they need.
package regseq_pkg;
  localparam int unsigned CMD_AW = 8;
  localparam int unsigned CMD_BW = 64;
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESP, VRD, VWAIT} state_t;
  typedef struct packed {
    logic              write;
    logic [CMD_AW-1:0] address;
    logic [CMD_BW-1:0] data;
  } cmd_t;
endpackage

// File: rtl/regseq_cmd_fifo.sv
// regseq_cmd_fifo: synchronous command FIFO with full/empty flags, power-of-two depth.
module regseq_cmd_fifo
  import regseq_pkg::*;
#(
  parameter  int P_Depth = 4,
  localparam int PW      = $clog2(P_Depth)
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic push_i,
  input  cmd_t data_i,
  input  logic pop_i,
  output cmd_t data_o,
  output logic full_o,
  output logic empty_o
);
  cmd_t          mem_q [P_Depth];
  logic [PW-1:0] wptr_q, rptr_q;
  logic [PW:0]   cnt_q;
  logic          push, pop;
  assign full_o  = cnt_q == (PW+1)'(P_Depth);
  assign empty_o = cnt_q == '0;
  assign data_o  = mem_q[rptr_q];
  assign push    = push_i && !full_o;
  assign pop     = pop_i && !empty_o;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + PW'(1);
      if (pop) rptr_q <= rptr_q + PW'(1);
      cnt_q <= cnt_q + (PW+1)'(push) - (PW+1)'(pop);
    end
  end
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wptr_q] <= data_i;
  end
endmodule

// File: rtl/regfile_access_sequencer.sv
// regfile_access_sequencer: buffers valid/ready register commands, issues single-cycle RF strobes, returns responses.
// Define REGSEQ_WRITE_VERIFY_EN to read back every in-range write and flag a mismatch as an error.
module regfile_access_sequencer
  import regseq_pkg::*;
#(
  parameter  int P_RegWidth    = 8,
  parameter  int P_BitWidth    = 32,
  parameter  int P_FifoDepth   = 4,
  parameter  int P_ReadLatency = 1,
  localparam int AW            = $clog2(P_RegWidth)
) (
  input  logic                  In_Clock_50MHz,
  input  logic                  In_Reset_n,
  input  logic                  In_CmdValid,
  output logic                  Out_CmdReady,
  input  logic                  In_CmdWrite,
  input  logic [AW-1:0]         In_CmdAddress,
  input  logic [P_BitWidth-1:0] In_CmdData,
  output logic                  Out_RspValid,
  input  logic                  In_RspReady,
  output logic [P_BitWidth-1:0] Out_RspData,
  output logic [AW-1:0]         Out_RspAddress,
  output logic                  Out_RspError,
  output logic [AW-1:0]         Out_RF_Address,
  output logic [P_BitWidth-1:0] Out_RF_WriteData,
  output logic                  Out_RF_Write,
  output logic                  Out_RF_Read,
  input  logic [P_BitWidth-1:0] In_RF_ReadData,
  output logic                  Out_Busy
);
  state_t                state_q, state_d;
  cmd_t                  cmd_in, head;
  logic                  full, empty, pop, in_range, last, unused_head;
  logic                  wr_q, wr_d, err_q, err_d;
  logic [1:0]            cnt_q, cnt_d;
  logic [AW-1:0]         rf_addr_q, rf_addr_d, rsp_addr_q, rsp_addr_d;
  logic [P_BitWidth-1:0] rf_wdata_q, rf_wdata_d, rsp_data_q, rsp_data_d;
  always_comb begin
    cmd_in         = '0;
    cmd_in.write   = In_CmdWrite;
    cmd_in.address = CMD_AW'(In_CmdAddress);
    cmd_in.data    = CMD_BW'(In_CmdData);
  end
  regseq_cmd_fifo #(.P_Depth(P_FifoDepth)) u_fifo (
    .clk_i  (In_Clock_50MHz),
    .rst_ni (In_Reset_n),
    .push_i (In_CmdValid),
    .data_i (cmd_in),
    .pop_i  (pop),
    .data_o (head),
    .full_o (full),
    .empty_o(empty)
  );
  assign unused_head = ^head.data[CMD_BW-1:P_BitWidth];
  assign in_range    = head.address < CMD_AW'(P_RegWidth);
  assign last        = cnt_q == 2'(P_ReadLatency);
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wr_d       = wr_q;
    err_d      = err_q;
    rf_addr_d  = rf_addr_q;
    rf_wdata_d = rf_wdata_q;
    rsp_addr_d = rsp_addr_q;
    rsp_data_d = rsp_data_q;
    pop        = 1'b0;
    case (state_q)
      IDLE: if (!empty) begin
        pop        = 1'b1;
        state_d    = ISSUE;
        wr_d       = head.write;
        err_d      = !in_range;
        rsp_addr_d = head.address[AW-1:0];
        rsp_data_d = '0;
        // RF bus only moves for commands that will actually strobe it
        rf_addr_d  = in_range ? head.address[AW-1:0] : rf_addr_q;
        rf_wdata_d = in_range && head.write ? head.data[P_BitWidth-1:0] : rf_wdata_q;
      end
      ISSUE: begin
        cnt_d = 2'd1;
`ifdef REGSEQ_WRITE_VERIFY_EN
        state_d = err_q ? RESP : wr_q ? VRD : WAIT;
`else
        state_d = err_q || wr_q ? RESP : WAIT;
`endif
      end
      WAIT: begin
        cnt_d = cnt_q + 2'd1;
        if (last) begin
          state_d    = RESP;
          rsp_data_d = In_RF_ReadData;
        end
      end
`ifdef REGSEQ_WRITE_VERIFY_EN
      VRD: begin
        cnt_d   = 2'd1;
        state_d = VWAIT;
      end
      VWAIT: begin
        cnt_d = cnt_q + 2'd1;
        if (last) begin
          state_d    = RESP;
          rsp_data_d = In_RF_ReadData;
          err_d      = In_RF_ReadData != rf_wdata_q;
        end
      end
`endif
      RESP: if (In_RspReady) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge In_Clock_50MHz or negedge In_Reset_n) begin
    if (!In_Reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      wr_q       <= 1'b0;
      err_q      <= 1'b0;
      rf_addr_q  <= '0;
      rf_wdata_q <= '0;
      rsp_addr_q <= '0;
      rsp_data_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wr_q       <= wr_d;
      err_q      <= err_d;
      rf_addr_q  <= rf_addr_d;
      rf_wdata_q <= rf_wdata_d;
      rsp_addr_q <= rsp_addr_d;
      rsp_data_q <= rsp_data_d;
    end
  end
  assign Out_CmdReady     = !full;
  assign Out_RspValid     = state_q == RESP;
  assign Out_RspData      = rsp_data_q;
  assign Out_RspAddress   = rsp_addr_q;
  assign Out_RspError     = err_q;
  assign Out_RF_Address   = rf_addr_q;
  assign Out_RF_WriteData = rf_wdata_q;
  assign Out_RF_Write     = state_q == ISSUE && wr_q && !err_q;
`ifdef REGSEQ_WRITE_VERIFY_EN
  assign Out_RF_Read      = (state_q == ISSUE && !wr_q && !err_q) || state_q == VRD;
`else
  assign Out_RF_Read      = state_q == ISSUE && !wr_q && !err_q;
`endif
  assign Out_Busy         = !empty || state_q != IDLE;
endmodule
